// File: rtl/line_count_irq_sched_pkg.sv
// Shared definitions for the line-counter interrupt scheduler: register
// word offsets, interrupt source indices and the controller state encoding.
package line_count_pkg;

    // Register word indices (byte address bits [4:2])
    localparam logic [2:0] REG_GIE    = 3'd0;
    localparam logic [2:0] REG_IER    = 3'd1;
    localparam logic [2:0] REG_ISR    = 3'd2;
    localparam logic [2:0] REG_IAR    = 3'd3;
    localparam logic [2:0] REG_IPR    = 3'd4;
    localparam logic [2:0] REG_CTRL   = 3'd5;
    localparam logic [2:0] REG_THRESH = 3'd6;
    localparam logic [2:0] REG_COUNT  = 3'd7;

    // Interrupt source bit positions
    localparam int INTR_THRESH = 0;
    localparam int INTR_FRAME  = 1;
    localparam int INTR_OVF    = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        COUNT = 2'd2,
        HALT  = 2'd3
    } fsm_state_e;

    // Word index of a byte address; the two low address bits are ignored
    function automatic logic [2:0] reg_word(input logic [4:0] addr);
        return addr[4:2];
    endfunction

endpackage

// File: rtl/line_count_irq_regs.sv
// Generic interrupt register block: GIE, IER, sticky ISR with
// write-1-to-clear IAR, IPR = ISR & IER, and a registered irq output in
// level or edge flavour.
module line_count_irq_regs #(
    parameter int C_NUM_INTR         = 3,
    parameter int C_IRQ_SENSITIVITY  = 1,
    parameter int C_IRQ_ACTIVE_STATE = 1
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  gie_wr,
    input  logic                  ier_wr,
    input  logic                  iar_wr,
    input  logic [C_NUM_INTR-1:0] wdata,
    input  logic [C_NUM_INTR-1:0] intr_set,
    output logic                  gie,
    output logic [C_NUM_INTR-1:0] ier,
    output logic [C_NUM_INTR-1:0] isr,
    output logic [C_NUM_INTR-1:0] ipr,
    output logic                  irq
);

    logic                  gie_reg;
    logic [C_NUM_INTR-1:0] ier_reg;
    logic [C_NUM_INTR-1:0] isr_reg;
    logic [C_NUM_INTR-1:0] isr_next;
    logic                  pending;
    logic                  irq_reg;

    // A new event on a source beats a simultaneous acknowledge of that source
    generate
        for (genvar gi = 0; gi < C_NUM_INTR; gi++) begin : g_isr
            assign isr_next[gi] = intr_set[gi] | (isr_reg[gi] & ~(iar_wr & wdata[gi]));
        end
    endgenerate

    // Enable and status registers
    always_ff @(posedge clk) begin
        if (srst) begin
            gie_reg <= 1'b0;
            ier_reg <= '0;
            isr_reg <= '0;
        end else begin
            if (gie_wr) gie_reg <= wdata[0];
            if (ier_wr) ier_reg <= wdata;
            isr_reg <= isr_next;
        end
    end

    assign pending = gie_reg & (|(isr_reg & ier_reg));

    generate
        if (C_IRQ_SENSITIVITY != 0) begin : g_level
            // Level irq follows the gated pending state one cycle later
            always_ff @(posedge clk) begin
                if (srst) irq_reg <= 1'b0;
                else      irq_reg <= pending;
            end
        end else begin : g_edge
            logic pending_prev_reg;
            // Edge irq is a single-cycle pulse on a rising pending state
            always_ff @(posedge clk) begin
                if (srst) begin
                    pending_prev_reg <= 1'b0;
                    irq_reg          <= 1'b0;
                end else begin
                    pending_prev_reg <= pending;
                    irq_reg          <= pending & ~pending_prev_reg;
                end
            end
        end
    endgenerate

    assign gie = gie_reg;
    assign ier = ier_reg;
    assign isr = isr_reg;
    assign ipr = isr_reg & ier_reg;
    assign irq = (C_IRQ_ACTIVE_STATE != 0) ? irq_reg : ~irq_reg;

endmodule

// File: rtl/line_count_irq_sched.sv
// Line-counter controller: register decode, CTRL/THRESH, the
// IDLE/ARMED/COUNT/HALT sequencer and the line counter. Interrupt
// bookkeeping lives in line_count_irq_regs.
module line_count_irq_sched
    import line_count_pkg::*;
#(
    parameter int C_CNT_WIDTH        = 16,
    parameter int C_NUM_INTR         = 3,
    parameter int C_IRQ_SENSITIVITY  = 1,
    parameter int C_IRQ_ACTIVE_STATE = 1
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic                   reg_wr_en,
    input  logic                   reg_rd_en,
    input  logic [4:0]             reg_addr,
    input  logic [31:0]            reg_wdata,
    output logic [31:0]            reg_rdata,
    output logic                   reg_rvalid,
    input  logic                   frame_sync,
    input  logic                   line_pulse,
    output logic [C_CNT_WIDTH-1:0] line_count,
    output logic                   irq
);

    logic [2:0]             word;
    logic                   wr_gie, wr_ier, wr_iar, wr_ctrl, wr_thresh;
    logic                   clear_req, run_eff;
    logic                   run_reg, periodic_reg;
    logic [C_CNT_WIDTH-1:0] thresh_reg;
    logic [C_CNT_WIDTH-1:0] cnt_reg;
    logic [C_CNT_WIDTH-1:0] cnt_inc;
    fsm_state_e             state_reg;
    logic                   counting, ev_frame, ev_step, ev_hit, ev_ovf;
    logic [C_NUM_INTR-1:0]  intr_set;
    logic                   gie;
    logic [C_NUM_INTR-1:0]  ier, isr, ipr;
    logic [31:0]            rd_mux;
    logic [31:0]            rdata_reg;
    logic                   rvalid_reg;
    logic                   unused_bits;

    assign word      = reg_word(reg_addr);
    assign wr_gie    = reg_wr_en && (word == REG_GIE);
    assign wr_ier    = reg_wr_en && (word == REG_IER);
    assign wr_iar    = reg_wr_en && (word == REG_IAR);
    assign wr_ctrl   = reg_wr_en && (word == REG_CTRL);
    assign wr_thresh = reg_wr_en && (word == REG_THRESH);

    // Clear is a strobe; the run value it pairs with is the one being written
    assign clear_req = wr_ctrl && reg_wdata[2];
    assign run_eff   = wr_ctrl ? reg_wdata[0] : run_reg;

    assign unused_bits = ^{reg_wdata, reg_addr[1:0]};

    // Counter events; frame_sync outranks line_pulse, clear suppresses both
    always_comb begin
        cnt_inc  = cnt_reg + 1'b1;
        counting = run_reg && !clear_req && (state_reg == COUNT);
        ev_frame = counting && frame_sync;
        ev_step  = counting && !frame_sync && line_pulse;
        ev_hit   = ev_step && (thresh_reg != '0) && (cnt_inc == thresh_reg);
        ev_ovf   = ev_step && (cnt_reg == '1);
        intr_set = '0;
        intr_set[INTR_THRESH] = ev_hit;
        intr_set[INTR_FRAME]  = ev_frame;
        intr_set[INTR_OVF]    = ev_ovf;
    end

    // CTRL and THRESH registers
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            run_reg      <= 1'b0;
            periodic_reg <= 1'b0;
            thresh_reg   <= '0;
        end else begin
            if (wr_ctrl) begin
                run_reg      <= reg_wdata[0];
                periodic_reg <= reg_wdata[1];
            end
            if (wr_thresh) thresh_reg <= reg_wdata[C_CNT_WIDTH-1:0];
        end
    end

    // Sequencer and line counter; dropping run parks in IDLE with the count held
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            if (run_reg) begin
                case (state_reg)
                    IDLE:  state_reg <= ARMED;
                    ARMED: if (frame_sync) begin
                        state_reg <= COUNT;
                        cnt_reg   <= '0;
                    end
                    COUNT: begin
                        if (ev_frame) begin
                            cnt_reg <= '0;
                        end else if (ev_step) begin
                            cnt_reg <= cnt_inc;
                            if (ev_hit && !periodic_reg) state_reg <= HALT;
                        end
                    end
                    HALT:  if (frame_sync) state_reg <= ARMED;
                    default: state_reg <= IDLE;
                endcase
            end else begin
                state_reg <= IDLE;
            end
            if (clear_req) begin
                cnt_reg <= '0;
                if (state_reg == COUNT || state_reg == HALT)
                    state_reg <= run_eff ? ARMED : IDLE;
            end
        end
    end

    // Read multiplexer; write-only and strobe bits read as 0
    always_comb begin
        rd_mux = 32'd0;
        case (word)
            REG_GIE:    rd_mux = {31'd0, gie};
            REG_IER:    rd_mux = 32'(ier);
            REG_ISR:    rd_mux = 32'(isr);
            REG_IPR:    rd_mux = 32'(ipr);
            REG_CTRL:   rd_mux = {30'd0, periodic_reg, run_reg};
            REG_THRESH: rd_mux = 32'(thresh_reg);
            REG_COUNT:  rd_mux = 32'(cnt_reg);
            default:    rd_mux = 32'd0;
        endcase
    end

    // One-cycle read response with pre-write register contents
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rdata_reg  <= 32'd0;
            rvalid_reg <= 1'b0;
        end else begin
            rvalid_reg <= reg_rd_en;
            if (reg_rd_en) rdata_reg <= rd_mux;
        end
    end

    line_count_irq_regs #(
        .C_NUM_INTR         (C_NUM_INTR),
        .C_IRQ_SENSITIVITY  (C_IRQ_SENSITIVITY),
        .C_IRQ_ACTIVE_STATE (C_IRQ_ACTIVE_STATE)
    ) u_irq_regs (
        .clk      (ACLK),
        .srst     (ARESET),
        .gie_wr   (wr_gie),
        .ier_wr   (wr_ier),
        .iar_wr   (wr_iar),
        .wdata    (reg_wdata[C_NUM_INTR-1:0]),
        .intr_set (intr_set),
        .gie      (gie),
        .ier      (ier),
        .isr      (isr),
        .ipr      (ipr),
        .irq      (irq)
    );

    assign reg_rdata  = rdata_reg;
    assign reg_rvalid = rvalid_reg;
    assign line_count = cnt_reg;

endmodule

// File: tb/tb_line_count_irq_sched.sv
// Bench for line_count_irq_sched: three builds share one stimulus stream
// (16-bit level irq, 4-bit level irq, 16-bit edge irq). Register reads are
// scored through a queue of expected values popped when rvalid appears.
module tb_line_count_irq_sched;

    localparam logic [4:0] A_GIE    = 5'h00;
    localparam logic [4:0] A_IER    = 5'h04;
    localparam logic [4:0] A_ISR    = 5'h08;
    localparam logic [4:0] A_IAR    = 5'h0C;
    localparam logic [4:0] A_IPR    = 5'h10;
    localparam logic [4:0] A_CTRL   = 5'h14;
    localparam logic [4:0] A_THRESH = 5'h18;
    localparam logic [4:0] A_COUNT  = 5'h1C;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        reg_wr_en, reg_rd_en;
    logic [4:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        frame_sync, line_pulse;

    logic [31:0] rdata_m, rdata_w4, rdata_e;
    logic        rvalid_m, rvalid_w4, rvalid_e;
    logic [15:0] count_m, count_e;
    logic [3:0]  count_w4;
    logic        irq_m, irq_w4, irq_e;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp_main;
        bit          chk_w4;
        logic [31:0] exp_w4;
    } rd_exp_t;

    rd_exp_t sb[$];

    always #5 ACLK = ~ACLK;

    line_count_irq_sched u_main (
        .ACLK(ACLK), .ARESET(ARESET), .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(rdata_m), .reg_rvalid(rvalid_m),
        .frame_sync(frame_sync), .line_pulse(line_pulse), .line_count(count_m), .irq(irq_m)
    );

    line_count_irq_sched #(.C_CNT_WIDTH(4)) u_w4 (
        .ACLK(ACLK), .ARESET(ARESET), .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(rdata_w4), .reg_rvalid(rvalid_w4),
        .frame_sync(frame_sync), .line_pulse(line_pulse), .line_count(count_w4), .irq(irq_w4)
    );

    line_count_irq_sched #(.C_IRQ_SENSITIVITY(0)) u_edge (
        .ACLK(ACLK), .ARESET(ARESET), .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(rdata_e), .reg_rvalid(rvalid_e),
        .frame_sync(frame_sync), .line_pulse(line_pulse), .line_count(count_e), .irq(irq_e)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        reg_wr_en = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        tick();
        reg_wr_en = 1'b0;
        $display("[TB] wr addr=0x%02h data=0x%0h", a, d);
    endtask

    task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] e,
                      input bit cw = 1'b0, input logic [31:0] ew = 32'd0);
        rd_exp_t x;
        x.tag = tag; x.exp_main = e; x.chk_w4 = cw; x.exp_w4 = ew;
        sb.push_back(x);
        reg_rd_en = 1'b1;
        reg_addr  = a;
        tick();
        reg_rd_en = 1'b0;
    endtask

    task automatic pulses(input int n);
        line_pulse = 1'b1;
        repeat (n) tick();
        line_pulse = 1'b0;
    endtask

    task automatic fsync();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
    endtask

    // Read response scoreboard
    always @(negedge ACLK) begin
        rd_exp_t e;
        if (rvalid_m) begin
            if (sb.size() == 0) begin
                check("rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                $display("[TB] rd %s rdata=0x%0h w4=0x%0h", e.tag, rdata_m, rdata_w4);
                check(e.tag, rdata_m, e.exp_main);
                if (e.chk_w4) begin
                    check({e.tag, "_w4"}, rdata_w4, e.exp_w4);
                    check({e.tag, "_w4_rvalid"}, 32'(rvalid_w4), 32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESET = 1'b1; reg_wr_en = 1'b0; reg_rd_en = 1'b0; reg_addr = '0; reg_wdata = '0;
        frame_sync = 1'b0; line_pulse = 1'b0;
        repeat (3) tick();
        check("rst_count", 32'(count_m), 32'd0);
        check("rst_irq", 32'(irq_m), 32'd0);
        check("rst_rvalid", 32'(rvalid_m), 32'd0);
        check("rst_rdata", rdata_m, 32'd0);
        ARESET = 1'b0;
        rd(A_GIE, "rst_gie", 0);
        rd(A_ISR, "rst_isr", 0);
        rd(A_CTRL, "rst_ctrl", 0);
        rd(A_THRESH, "rst_thresh", 0);

        // One-shot threshold hit
        wr(A_GIE, 1); wr(A_IER, 1); wr(A_THRESH, 4); wr(A_CTRL, 1);
        tick();
        fsync();
        pulses(3);
        check("oneshot_cnt3", 32'(count_m), 3);
        pulses(1);
        check("oneshot_cnt4", 32'(count_m), 4);
        check("irq_latency_lo", 32'(irq_m), 0);
        tick();
        check("irq_level_hi", 32'(irq_m), 1);
        check("irq_edge_hi", 32'(irq_e), 1);
        tick();
        check("irq_level_hold", 32'(irq_m), 1);
        check("irq_edge_pulse_end", 32'(irq_e), 0);
        rd(A_ISR, "oneshot_isr", 1);
        rd(A_IPR, "oneshot_ipr", 1);
        rd(A_COUNT, "oneshot_count", 4);
        pulses(2);
        check("halt_hold", 32'(count_m), 4);

        // Acknowledge
        wr(A_IAR, 1);
        check("iar_irq_lag", 32'(irq_m), 1);
        tick();
        check("iar_irq_lo", 32'(irq_m), 0);
        rd(A_IPR, "iar_ipr", 0);
        rd(A_ISR, "iar_isr", 0);
        rd(A_IAR, "iar_reads0", 0);

        // Threshold hit coinciding with an IAR write
        fsync();
        fsync();
        pulses(3);
        reg_wr_en = 1'b1; reg_addr = A_IAR; reg_wdata = 32'd1; line_pulse = 1'b1;
        tick();
        reg_wr_en = 1'b0; line_pulse = 1'b0;
        $display("[TB] wr addr=0x%02h data=0x1 with line_pulse", A_IAR);
        check("setwin_cnt", 32'(count_m), 4);
        rd(A_ISR, "setwin_isr", 1);
        check("setwin_irq", 32'(irq_m), 1);

        // Global enable gating
        wr(A_GIE, 0);
        tick();
        check("gie0_irq", 32'(irq_m), 0);
        rd(A_IPR, "gie0_ipr", 1);
        check("gie0_irq_hold", 32'(irq_m), 0);
        check("gie0_irq_edge", 32'(irq_e), 0);
        wr(A_GIE, 1);
        check("gie1_lat", 32'(irq_m), 0);
        tick();
        check("gie1_irq", 32'(irq_m), 1);
        check("gie1_edge", 32'(irq_e), 1);
        tick();
        check("gie1_irq_hold", 32'(irq_m), 1);
        check("gie1_edge_once", 32'(irq_e), 0);
        tick();
        check("gie1_edge_quiet", 32'(irq_e), 0);

        // Periodic mode and frame end
        wr(A_THRESH, 2); wr(A_IER, 3); wr(A_IAR, 7); wr(A_CTRL, 7);
        check("clear_cnt", 32'(count_m), 0);
        rd(A_CTRL, "ctrl_readback", 3);
        fsync();
        pulses(2);
        check("per_cnt2", 32'(count_m), 2);
        rd(A_ISR, "per_isr_hit", 1);
        pulses(3);
        check("per_continue", 32'(count_m), 5);
        fsync();
        check("frame_reload", 32'(count_m), 0);
        rd(A_ISR, "frame_isr", 3);
        rd(A_IPR, "frame_ipr", 3);
        pulses(2);
        frame_sync = 1'b1; line_pulse = 1'b1;
        tick();
        frame_sync = 1'b0; line_pulse = 1'b0;
        check("fs_wins", 32'(count_m), 0);

        // Counter wrap (4-bit build) with THRESH=0
        wr(A_IAR, 7); wr(A_THRESH, 0); wr(A_IER, 7); wr(A_CTRL, 5);
        fsync();
        pulses(15);
        check("wrap_pre_w4", 32'(count_w4), 15);
        pulses(1);
        check("wrap_main", 32'(count_m), 16);
        check("wrap_w4", 32'(count_w4), 0);
        rd(A_ISR, "wrap_isr", 0, 1'b1, 4);
        check("wrap_irq_w4", 32'(irq_w4), 1);
        check("wrap_irq_main", 32'(irq_m), 0);

        // run=0 holds the counter
        wr(A_CTRL, 0);
        pulses(2);
        check("run0_hold", 32'(count_m), 16);
        rd(A_COUNT, "run0_count", 16, 1'b1, 0);

        // Simultaneous read and write returns the old value
        reg_wr_en = 1'b1; reg_rd_en = 1'b1; reg_addr = A_THRESH; reg_wdata = 32'd9;
        begin
            rd_exp_t x;
            x.tag = "rdwr_old"; x.exp_main = 0; x.chk_w4 = 1'b1; x.exp_w4 = 0;
            sb.push_back(x);
        end
        tick();
        reg_wr_en = 1'b0; reg_rd_en = 1'b0;
        rd(A_THRESH, "rdwr_new", 9, 1'b1, 9);

        // Reset in the middle of a frame
        wr(A_IAR, 7); wr(A_CTRL, 5);
        tick();
        fsync();
        pulses(3);
        check("midrst_cnt3", 32'(count_m), 3);
        ARESET = 1'b1;
        tick();
        check("midrst_count", 32'(count_m), 0);
        check("midrst_irq", 32'(irq_m), 0);
        check("midrst_rvalid", 32'(rvalid_m), 0);
        ARESET = 1'b0;
        rd(A_CTRL, "midrst_ctrl", 0);
        rd(A_THRESH, "midrst_thresh", 0);
        rd(A_GIE, "midrst_gie", 0);
        rd(A_ISR, "midrst_isr", 0);
        fsync();
        pulses(2);
        check("post_rst_ignore", 32'(count_m), 0);

        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
